// File: rtl/hilo_mdu_pkg.sv
// Shared MDU definitions: op encodings, FSM state type, result record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: OP_* encodings of the 3-bit op field, mdu_state_t, hilo_t,
//           is_long_op()/is_div_op() classifiers.
package hilo_mdu_pkg;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MFHI  = 3'd5;
    localparam logic [2:0] OP_MFLO  = 3'd6;
    localparam logic [2:0] OP_MT    = 3'd7;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    // Result of a multi-cycle op; wr=0 means HI/LO must be left untouched
    // (divide by zero).
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wr;
    } hilo_t;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_mdu_if.sv
// E-stage <-> MDU bundle: op request, operands, D-stage hazard hint, status.
// Latency: n/a (wires only).
// Backpressure: busy/stall_req tell the pipeline to hold; no valid/ready.
// Ports: master = pipeline side (drives start/op/sel_lo/a/b/d_uses_hilo),
//        slave  = MDU side (drives busy/stall_req/hilo_result/hi/lo).
interface hilo_mdu_if;
    logic        start;
    logic [2:0]  op;
    logic        sel_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_uses_hilo;
    logic        busy;
    logic        stall_req;
    logic [31:0] hilo_result;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, sel_lo, a, b, d_uses_hilo,
        input  busy, stall_req, hilo_result, hi, lo
    );

    modport slave (
        input  start, op, sel_lo, a, b, d_uses_hilo,
        output busy, stall_req, hilo_result, hi, lo
    );
endinterface

// File: rtl/hilo_mdu_calc.sv
// Combinational 64-bit result formation for mult/multu/div/divu.
// Latency: 0 cycles (pure combinational from latched operands).
// Backpressure: none.
// Ports: op/a/b in (latched copies), res out (hi, lo, wr).
module hilo_mdu_calc
    import hilo_mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output hilo_t       res
);

    logic [63:0] prod;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        res   = '0;
        prod  = '0;
        q_mag = '0;
        r_mag = '0;

        // Signed divide works on magnitudes so that 0x80000000 / -1 never
        // overflows: its magnitude 0x80000000 divides cleanly as unsigned.
        sgn   = (op == OP_MULT) || (op == OP_DIV);
        a_neg = sgn & a[31];
        b_neg = sgn & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end

        case (op)
            OP_MULT: begin
                // Low 64 bits of a 64x64 product of sign-extended operands
                // equal the signed 32x32 product.
                prod   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
                res.wr = 1'b1;
            end
            OP_MULTU: begin
                prod   = {32'd0, a} * {32'd0, b};
                res.hi = prod[63:32];
                res.lo = prod[31:0];
                res.wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // Quotient truncates toward zero; remainder follows dividend.
                res.lo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
                res.hi = a_neg ? (~r_mag + 32'd1) : r_mag;
                res.wr = (b != 32'd0);
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/hilo_mdu.sv
// E-stage multiply/divide unit owning architectural HI/LO.
// Latency: mult N=MULT_CYCLES, div N=DIV_CYCLES busy cycles; HI/LO update on
//          the edge busy falls; mthi/mtlo write on the start edge.
// Backpressure: busy high while in flight, starts during busy are dropped;
//               stall_req holds a dependent D-stage instruction.
// Ports: clk, reset (sync, active-low), bus (hilo_mdu_if.slave).
// MULT_CYCLES and DIV_CYCLES must both be >= 1.
module hilo_mdu
    import hilo_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    hilo_mdu_if.slave  bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    mdu_state_t  state;
    logic        busy_q;
    logic [CW-1:0] cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    hilo_t       res;
    logic        long_start;

    assign long_start = bus.start && is_long_op(bus.op);

    hilo_mdu_calc u_calc (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .res (res)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            op_q   <= OP_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (long_start) begin
                        state  <= S_BUSY;
                        busy_q <= 1'b1;
                        cnt    <= is_div_op(bus.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        op_q   <= bus.op;
                        a_q    <= bus.a;
                        b_q    <= bus.b;
                    end else if (bus.start && (bus.op == OP_MT)) begin
                        if (bus.sel_lo) begin
                            lo_q <= bus.a;
                        end else begin
                            hi_q <= bus.a;
                        end
                    end
                end
                S_BUSY: begin
                    // Commit on the edge the counter would reach zero so busy
                    // stays high for exactly N cycles after the start edge.
                    if (cnt == CW'(1)) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        if (res.wr) begin
                            hi_q <= res.hi;
                            lo_q <= res.lo;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Covers the start cycle too, before busy has risen.
    assign bus.stall_req = bus.d_uses_hilo && (busy_q || long_start);

    always_comb begin
        bus.hilo_result = '0;
        if (bus.op == OP_MFHI) begin
            bus.hilo_result = hi_q;
        end else if (bus.op == OP_MFLO) begin
            bus.hilo_result = lo_q;
        end
    end

endmodule
